// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the display scan path.
// Segment vectors are active-high with bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-high seven-segment pattern.
// Non-decimal codes show a dash so corrupted input is visible on the display.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner with frame snapshot, leading-zero
// blanking, fixed decimal point and inter-digit anode dead time.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLOCKSPEED     = 12000000,
    parameter int NUMCELLS       = 4,
    parameter int REFRESH_HZ     = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int DP_POS         = 2,
    parameter int BLANK_LEADING  = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic [4*NUMCELLS-1:0]   bcd,
    input  logic                    freeze,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUMCELLS-1:0]     an,
    output logic                    frame_start
);

    localparam int DIV = CLOCKSPEED / REFRESH_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = (NUMCELLS > 1) ? $clog2(NUMCELLS) : 1;

    localparam logic [CW-1:0]       CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]       CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0]       IDX_LAST  = IW'(NUMCELLS - 1);
    localparam logic [NUMCELLS-1:0] AN_POL    = (AN_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0]          SEG_POL   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                DP_POL    = (SEG_ACTIVE_LOW != 0);

    generate
        if (DIV <= BLANK_CYCLES) begin : g_bad_div
            $error("seg_scan_driver: slot length DIV must exceed BLANK_CYCLES");
        end
    endgenerate

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUMCELLS-1:0]   shadow;

    logic                    tick;
    logic                    wrap;
    logic [NUMCELLS-1:0]     blank_vec;
    logic                    zero_above;
    logic [3:0]              nibble_p0;
    logic                    blank_p0;
    logic [6:0]              pattern_p0;
    logic                    an_on_p0;
    logic [NUMCELLS-1:0]     an_p0;
    logic [6:0]              seg_p0;
    logic                    dp_p0;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Stage p0: blanking mask from the snapshot, current digit select and decode.
    always_comb begin
        zero_above = 1'b1;
        blank_vec  = '0;
        for (int j = NUMCELLS - 1; j >= 0; j--) begin
            zero_above = zero_above && (shadow[4*j +: 4] == 4'd0);
            if ((BLANK_LEADING != 0) && (j > DP_POS) && (j > 0) && zero_above)
                blank_vec[j] = 1'b1;
        end
    end

    always_comb begin
        nibble_p0 = 4'd0;
        blank_p0  = 1'b0;
        for (int j = 0; j < NUMCELLS; j++) begin
            if (idx == IW'(j)) begin
                nibble_p0 = shadow[4*j +: 4];
                blank_p0  = blank_vec[j];
            end
        end
    end

    bcd_to_seg u_decode (
        .nibble  (nibble_p0),
        .pattern (pattern_p0)
    );

    // The anode stays dark for the first BLANK_CYCLES of each slot so the
    // previous digit's segments never ghost onto the next one.
    always_comb begin
        an_on_p0 = (cnt >= CNT_BLANK) && !blank_p0;
        an_p0    = '0;
        for (int j = 0; j < NUMCELLS; j++) begin
            if (an_on_p0 && (idx == IW'(j)))
                an_p0[j] = 1'b1;
        end
        seg_p0 = blank_p0 ? SEG_OFF : pattern_p0;
        dp_p0  = an_on_p0 && (int'(idx) == DP_POS);
    end

    // Stage p1: scan state, snapshot and registered pin drivers.
    always_ff @(posedge clock) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            shadow      <= '0;
            frame_start <= 1'b0;
            an          <= AN_POL;
            seg         <= SEG_POL;
            dp          <= DP_POL;
        end else begin
            cnt         <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (wrap && !freeze)
                shadow <= bcd;
            frame_start <= wrap;
            an          <= an_p0 ^ AN_POL;
            seg         <= seg_p0 ^ SEG_POL;
            dp          <= dp_p0 ^ DP_POL;
        end
    end

endmodule
